// File: rtl/phase_ping_pkg.sv
// Shared definitions for the phase-ping serial path.
// Holds the receiver FSM state encoding, the single-byte command codes and
// the default clock / baud figures shared with the transmitter and capture
// stages.
package phase_ping_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_e;

  localparam logic [7:0] CMD_TRIG = 8'h54;  // 'T'
  localparam logic [7:0] CMD_CLR  = 8'h52;  // 'R'

  localparam int DEF_CLK_FREQ = 48000000;
  localparam int DEF_SYM_RATE = 1200;

endpackage

// File: rtl/rx_sync2.sv
// Two-flop synchronizer for the asynchronous UART line.
// Both flops reset to 1 so an idle-high line never looks like a start bit
// coming out of reset.
// Ports:
//   clk  in  system clock
//   rst  in  synchronous active-low reset
//   d    in  asynchronous input
//   q    out synchronized output (second flop)
module rx_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic s1_q, s2_q;
  logic s1_d, s2_d;

  always_comb begin
    s1_d = d;
    s2_d = s1_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/uart_cmd_rx.sv
// 8N1 UART receiver with single-byte command decode.
// Deserializes bytes from fpga_rx_pin, counts accepted bytes modulo 256,
// fires trig on TRIG_BYTE and clears the counter on CLR_BYTE.
// Ports:
//   clk          in  system clock, rising edge
//   rst          in  synchronous active-low reset
//   fpga_rx_pin  in  asynchronous UART line, idle high
//   rx_byte      out last accepted data byte
//   rx_valid     out one-cycle pulse when rx_byte is updated
//   trig         out one-cycle pulse when the accepted byte is TRIG_BYTE
//   rx_counter   out accepted-byte count, modulo 256
//   frame_err    out one-cycle pulse when the stop bit is sampled low
//   rx_busy      out high while a frame is in progress
module uart_cmd_rx
  import phase_ping_pkg::*;
#(
  parameter int         CLK_FREQ  = DEF_CLK_FREQ,
  parameter int         SYM_RATE  = DEF_SYM_RATE,
  parameter logic [7:0] TRIG_BYTE = CMD_TRIG,
  parameter logic [7:0] CLR_BYTE  = CMD_CLR
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       fpga_rx_pin,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       trig,
  output logic [7:0] rx_counter,
  output logic       frame_err,
  output logic       rx_busy
);

  localparam int SYM_CNT = CLK_FREQ / SYM_RATE;
  localparam int SCW     = $clog2(SYM_CNT);

  localparam logic [SCW-1:0] HALF_LAST = SCW'(SYM_CNT / 2 - 1);
  localparam logic [SCW-1:0] BIT_LAST  = SCW'(SYM_CNT - 1);

  logic rxs;

  rx_sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .d   (fpga_rx_pin),
    .q   (rxs)
  );

  rx_state_e      state_q, state_d;
  logic [SCW-1:0] timer_q, timer_d;
  logic [2:0]     idx_q, idx_d;
  logic [7:0]     shreg_q, shreg_d;
  logic           armed_q, armed_d;
  logic [7:0]     byte_q, byte_d;
  logic [7:0]     cnt_q, cnt_d;
  logic           valid_q, valid_d;
  logic           trig_q, trig_d;
  logic           ferr_q, ferr_d;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    armed_d = armed_q;
    byte_d  = byte_q;
    cnt_d   = cnt_q;
    valid_d = 1'b0;
    trig_d  = 1'b0;
    ferr_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        timer_d = '0;
        idx_d   = '0;
        // armed blocks a line stuck low (e.g. after a framing error) from
        // being taken as an endless stream of start bits.
        if (rxs) begin
          armed_d = 1'b1;
        end else if (armed_q) begin
          state_d = ST_START;
          armed_d = 1'b0;
        end
      end

      ST_START: begin
        if (timer_q == HALF_LAST) begin
          timer_d = '0;
          if (rxs) begin
            // Start bit gone by mid-bit: glitch. Line is high, so re-arm.
            state_d = ST_IDLE;
            armed_d = 1'b1;
          end else begin
            state_d = ST_DATA;
          end
        end else begin
          timer_d = timer_q + SCW'(1);
        end
      end

      ST_DATA: begin
        if (timer_q == BIT_LAST) begin
          timer_d        = '0;
          shreg_d[idx_q] = rxs;
          idx_d          = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = ST_STOP;
        end else begin
          timer_d = timer_q + SCW'(1);
        end
      end

      ST_STOP: begin
        if (timer_q == BIT_LAST) begin
          timer_d = '0;
          state_d = ST_IDLE;
          if (rxs) begin
            // Valid stop bit means the line is high: arm now so a start bit
            // arriving right after the stop bit is not missed.
            armed_d = 1'b1;
            byte_d  = shreg_q;
            valid_d = 1'b1;
            trig_d  = (shreg_q == TRIG_BYTE);
            cnt_d   = (shreg_q == CLR_BYTE) ? 8'd0 : cnt_q + 8'd1;
          end else begin
            ferr_d = 1'b1;
          end
        end else begin
          timer_d = timer_q + SCW'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      armed_q <= 1'b0;
      byte_q  <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      trig_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      armed_q <= armed_d;
      byte_q  <= byte_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      trig_q  <= trig_d;
      ferr_q  <= ferr_d;
    end
  end

  assign rx_byte    = byte_q;
  assign rx_valid   = valid_q;
  assign trig       = trig_q;
  assign rx_counter = cnt_q;
  assign frame_err  = ferr_q;
  assign rx_busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Scoreboard bench for uart_cmd_rx, run at a reduced bit period so the
// 256-byte wrap test stays short.
module tb_uart_cmd_rx;

  localparam int CLK_FREQ = 10;
  localparam int SYM_RATE = 1;
  localparam int SYM      = CLK_FREQ / SYM_RATE;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       pin = 1'b1;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       trig;
  logic [7:0] rx_counter;
  logic       frame_err;
  logic       rx_busy;

  uart_cmd_rx #(
    .CLK_FREQ (CLK_FREQ),
    .SYM_RATE (SYM_RATE)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .fpga_rx_pin (pin),
    .rx_byte     (rx_byte),
    .rx_valid    (rx_valid),
    .trig        (trig),
    .rx_counter  (rx_counter),
    .frame_err   (frame_err),
    .rx_busy     (rx_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       ferr;
    logic [7:0] b;
    logic       trg;
    logic [7:0] cnt;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state: what the host-visible outputs should hold.
  logic [7:0] m_last = 8'h00;
  logic [7:0] m_cnt  = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every output pulse must match the oldest expected frame.
  always @(negedge clk) begin
    if (rst && (rx_valid || frame_err || trig)) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: got valid=%b ferr=%b trig=%b expected none",
                 rx_valid, frame_err, trig);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("rx_valid",   rx_valid,   !e.ferr);
        chk("frame_err",  frame_err,  e.ferr);
        chk("trig",       trig,       e.trg);
        chk("rx_byte",    rx_byte,    e.b);
        chk("rx_counter", rx_counter, e.cnt);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic hold(input logic v, input int n);
    pin = v;
    repeat (n) tick();
  endtask

  // Drive one frame and predict its outcome from the protocol rules.
  task automatic send_frame(input logic [7:0] b, input logic stop);
    exp_t e;
    if (stop) begin
      m_last = b;
      m_cnt  = (b == 8'h52) ? 8'd0 : m_cnt + 8'd1;
    end
    e.ferr = !stop;
    e.b    = m_last;
    e.trg  = stop && (b == 8'h54);
    e.cnt  = m_cnt;
    q.push_back(e);
    hold(1'b0, SYM);
    for (int i = 0; i < 8; i++) hold(b[i], SYM);
    hold(stop, SYM);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rx_byte"},    rx_byte,    8'h00);
    chk({tag, "_rx_counter"}, rx_counter, 8'h00);
    chk({tag, "_rx_valid"},   rx_valid,   1'b0);
    chk({tag, "_trig"},       trig,       1'b0);
    chk({tag, "_frame_err"},  frame_err,  1'b0);
    chk({tag, "_rx_busy"},    rx_busy,    1'b0);
  endtask

  initial begin
    logic [7:0] rb;
    logic       rs;
    logic       seen_busy;
    int         budget;

    rst = 1'b0;
    pin = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    check_reset_outputs("reset");
    tick();
    rst = 1'b1;
    hold(1'b1, 2 * SYM);

    // Basic bytes.
    send_frame(8'h41, 1'b1);
    chk("after_41_counter", rx_counter, 8'd1);
    send_frame(8'h54, 1'b1);
    chk("after_54_counter", rx_counter, 8'd2);

    // Clear, then wrap the counter with 256 back-to-back bytes.
    send_frame(8'h52, 1'b1);
    for (int i = 0; i < 256; i++) send_frame(8'h00, 1'b1);
    chk("wrap_counter", rx_counter, 8'd0);
    send_frame(8'h52, 1'b1);
    chk("clr_after_wrap", rx_counter, 8'd0);

    // Random traffic with occasional framing errors and random gaps.
    for (int i = 0; i < 24; i++) begin
      rb = 8'($urandom_range(0, 255));
      if (i % 6 == 0) rb = 8'h54;
      if (i % 7 == 3) rb = 8'h52;
      rs = ($urandom_range(0, 4) != 0);
      send_frame(rb, rs);
      if (!rs) hold(1'b1, 2 * SYM);
      else     hold(1'b1, $urandom_range(0, 2) * SYM);
    end

    // Framing error with the line left low: no new frame until it rises.
    send_frame(8'h55, 1'b0);
    pin = 1'b0;
    for (int i = 0; i < 4; i++) begin
      repeat (SYM) tick();
      chk("held_low_busy", rx_busy, 1'b0);
    end
    hold(1'b1, 2 * SYM);
    send_frame(8'h33, 1'b1);

    // Short low glitch in idle: START entered and abandoned, no pulse.
    hold(1'b1, SYM);
    pin = 1'b0;
    seen_busy = 1'b0;
    for (int i = 0; i < 2 * SYM; i++) begin
      if (i == (3 * SYM) / 10) pin = 1'b1;
      tick();
      if (rx_busy) seen_busy = 1'b1;
    end
    chk("glitch_seen_busy", seen_busy, 1'b1);
    chk("glitch_busy_end",  rx_busy,   1'b0);
    chk("glitch_counter",   rx_counter, m_cnt);

    // Reset in the middle of data bit 4.
    hold(1'b0, SYM);
    for (int i = 0; i < 4; i++) hold(i[0], SYM);
    hold(1'b1, SYM / 2);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("midreset");
    m_cnt  = 8'h00;
    m_last = 8'h00;
    pin = 1'b1;
    tick();
    rst = 1'b1;
    hold(1'b1, 2 * SYM);
    send_frame(8'h54, 1'b1);
    chk("post_reset_counter", rx_counter, 8'd1);

    // Drain: every expected frame must have been seen.
    budget = 0;
    while (q.size() != 0 && budget < 20 * SYM) begin
      tick();
      budget++;
    end
    chk("scoreboard_empty", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
